// File: rtl/edge_arb_pkg.sv
// Shared definitions for the edge event arbiter: FSM states and the
// modulo-N pointer increment used by the round-robin logic.
package edge_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } arb_state_e;

    // Explicit compare keeps non-power-of-2 channel counts legal.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v == n - 32'd1) ? 32'd0 : v + 32'd1;
    endfunction

endpackage

// File: rtl/edge_rr_pick.sv
// Combinational round-robin finder: first set request at or after ptr,
// wrapping modulo N.
module edge_rr_pick #(
    parameter  int unsigned N   = 4,
    localparam int unsigned IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           found,
    output logic [IDW-1:0] idx
);

    int unsigned pos;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int unsigned off = 0; off < N; off++) begin
            pos = 32'(ptr) + off;
            if (pos >= N) pos = pos - N;
            if (!found && req[IDW'(pos)]) begin
                found = 1'b1;
                idx   = IDW'(pos);
            end
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Captures masked rising edges on N level inputs and serialises them as
// round-robin event tokens on a valid/ready interface.
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter  int unsigned N   = 4,
    localparam int unsigned IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   in,
    input  logic [N-1:0]   mask,
    output logic           out_valid,
    output logic [IDW-1:0] out_id,
    input  logic           out_ready,
    output logic [N-1:0]   pending,
    output logic [N-1:0]   overflow,
    input  logic [N-1:0]   overflow_clr
);

    arb_state_e     state_q, state_d;
    logic [N-1:0]   in_reg_q;
    logic [N-1:0]   pending_q, pending_d;
    logic [N-1:0]   overflow_q, overflow_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] out_id_q, out_id_d;

    logic [N-1:0]   edge_det;
    logic [N-1:0]   ovf_set;
    logic [N-1:0]   clr_vec;
    logic [IDW-1:0] next_ptr;
    logic [IDW-1:0] pick_ptr;
    logic           pick_found;
    logic [IDW-1:0] pick_idx;
    logic           load;

    // During a handshake the search starts just past the token being retired.
    always_comb begin
        next_ptr = IDW'(wrap_inc(32'(out_id_q), N));
        pick_ptr = (state_q == ST_OFFER) ? next_ptr : ptr_q;
    end

    edge_rr_pick #(.N(N)) u_pick (
        .req   (pending_q),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        out_id_d = out_id_q;
        load     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    load    = 1'b1;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (out_ready) begin
                    ptr_d = next_ptr;
                    if (pick_found) load = 1'b1;
                    else            state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) out_id_d = pick_idx;
        clr_vec = load ? (N'(1) << pick_idx) : '0;
    end

    // A fresh edge on the bit being loaded re-arms it without flagging overflow.
    always_comb begin
        edge_det   = in & ~in_reg_q & mask;
        ovf_set    = edge_det & pending_q & ~clr_vec;
        pending_d  = (pending_q & ~clr_vec) | edge_det;
        overflow_d = (overflow_q & ~overflow_clr) | ovf_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            in_reg_q   <= '0;
            pending_q  <= '0;
            overflow_q <= '0;
            ptr_q      <= '0;
            out_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            in_reg_q   <= in;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            ptr_q      <= ptr_d;
            out_id_q   <= out_id_d;
        end
    end

    always_comb begin
        out_valid = (state_q == ST_OFFER);
        out_id    = out_id_q;
        pending   = pending_q;
        overflow  = overflow_q;
    end

endmodule
